// File: rtl/types.sv
// Shared flit and node-id types for the router datapath.
package types;

    typedef logic [3:0] node_id_t;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'd0,
        FLIT_BODY     = 2'd1,
        FLIT_TAIL     = 2'd2,
        FLIT_HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t flit_type;
        node_id_t   global_dst_id;
        logic [25:0] payload;
    } flit_t;

endpackage

// File: rtl/packet_context_decoder.sv
// Per-channel packet context tracker: latches routing fields from each head flit,
// tags the rest of the packet with them, checks framing and registers the result
// behind a valid/ready output stage.
module packet_context_decoder #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned MAX_FLITS = 16,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned IDX_W    = $clog2(MAX_FLITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  types::node_id_t      this_node_id,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  types::flit_t         in_flit,
    input  logic [CH_W-1:0]      in_channel,
    input  logic                 in_from_cpu,
    output logic                 out_valid,
    input  logic                 out_ready,
    output types::flit_t         out_flit,
    output logic [CH_W-1:0]      out_channel,
    output logic                 out_is_destination_self,
    output logic                 out_is_source_self,
    output types::node_id_t      out_global_destination,
    output logic [IDX_W-1:0]     out_flit_index,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {StIdle, StActive} ch_state_e;

    localparam logic [CH_W:0]    NumChL  = NUM_CH[CH_W:0];
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(MAX_FLITS - 1);

    ch_state_e        state_q [NUM_CH];
    ch_state_e        state_d [NUM_CH];
    logic [IDX_W-1:0] idx_q   [NUM_CH];
    logic [IDX_W-1:0] idx_d   [NUM_CH];
    types::node_id_t  dst_q   [NUM_CH];
    logic             dself_q [NUM_CH];
    logic             sself_q [NUM_CH];

    logic            accept, ch_ok, is_head;
    logic [CH_W-1:0] ch_sel;
    logic            emit, load_ctx, go_active, go_idle, idx_inc;
    logic [1:0]      err;
    logic [IDX_W-1:0] emit_idx;
    logic            emit_dself, emit_sself;
    types::node_id_t emit_dst;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign ch_ok    = {1'b0, in_channel} < NumChL;
    // Out-of-range channels are steered to 0 only to keep array reads in bounds.
    assign ch_sel   = ch_ok ? in_channel : '0;
    assign is_head  = (in_flit.flit_type == types::FLIT_HEAD) ||
                      (in_flit.flit_type == types::FLIT_HEADTAIL);

    // Per-channel state register, updated only on the addressed channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= StIdle;
                idx_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                idx_q[c]   <= idx_d[c];
            end
        end
    end

    // Next-state for the addressed channel; every other channel holds.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            idx_d[c]   = idx_q[c];
        end
        if (accept && ch_ok) begin
            if (go_active) begin
                state_d[ch_sel] = StActive;
                idx_d[ch_sel]   = IDX_W'(1);
            end else if (go_idle) begin
                state_d[ch_sel] = StIdle;
                idx_d[ch_sel]   = '0;
            end else if (idx_inc) begin
                idx_d[ch_sel] = idx_q[ch_sel] + IDX_W'(1);
            end
        end
    end

    // Flit decode: what to emit, which error to flag and how the channel moves.
    always_comb begin
        emit      = 1'b0;
        load_ctx  = 1'b0;
        go_active = 1'b0;
        go_idle   = 1'b0;
        idx_inc   = 1'b0;
        err       = 2'd0;
        if (!ch_ok) begin
            err = 2'd1;
        end else if (is_head) begin
            // A head inside an open packet abandons it and restarts from here.
            if (state_q[ch_sel] == StActive) err = 2'd2;
            emit      = 1'b1;
            load_ctx  = 1'b1;
            go_active = (in_flit.flit_type == types::FLIT_HEAD);
            go_idle   = !go_active;
        end else begin
            unique case (state_q[ch_sel])
                StIdle: err = 2'd1;
                StActive: begin
                    if (in_flit.flit_type == types::FLIT_TAIL) begin
                        emit    = 1'b1;
                        go_idle = 1'b1;
                    end else if (idx_q[ch_sel] == LastIdx) begin
                        err     = 2'd3;
                        go_idle = 1'b1;
                    end else begin
                        emit    = 1'b1;
                        idx_inc = 1'b1;
                    end
                end
            endcase
        end
        emit_idx   = is_head ? '0 : idx_q[ch_sel];
        emit_dst   = load_ctx ? in_flit.global_dst_id : dst_q[ch_sel];
        emit_dself = load_ctx ? (in_flit.global_dst_id == this_node_id) : dself_q[ch_sel];
        emit_sself = load_ctx ? in_from_cpu : sself_q[ch_sel];
    end

    // Latch routing context from accepted heads; node id is sampled only here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                dst_q[c]   <= '0;
                dself_q[c] <= 1'b0;
                sself_q[c] <= 1'b0;
            end
        end else if (accept && load_ctx) begin
            dst_q[ch_sel]   <= in_flit.global_dst_id;
            dself_q[ch_sel] <= (in_flit.global_dst_id == this_node_id);
            sself_q[ch_sel] <= in_from_cpu;
        end
    end

    // Output register: load on emit, drain on out_ready, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid               <= 1'b0;
            out_flit                <= '0;
            out_channel             <= '0;
            out_is_destination_self <= 1'b0;
            out_is_source_self      <= 1'b0;
            out_global_destination  <= '0;
            out_flit_index          <= '0;
        end else if (accept && emit) begin
            out_valid               <= 1'b1;
            out_flit                <= in_flit;
            out_channel             <= in_channel;
            out_is_destination_self <= emit_dself;
            out_is_source_self      <= emit_sself;
            out_global_destination  <= emit_dst;
            out_flit_index          <= emit_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Error reporting: one-cycle pulse plus saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && (err != 2'd0);
            err_code  <= accept ? err : 2'd0;
            if (accept && (err != 2'd0) && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule
